// File: rtl/ahb_ic_pkg.sv
// Shared AHB interconnect definitions: transfer/response encodings and default-slave states.
package ahb_ic_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // NONSEQ and SEQ are the only transfer types that need a real response.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_interconnect_if.sv
// Bus bundle between the AHB master/slaves and the interconnect.
//   slave  modport: the interconnect's view (decodes master, muxes slave responses)
//   master modport: the environment's view (master + slave models)
interface ahb_interconnect_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SLAVE_NUM  = 4
);
    logic [ADDR_WIDTH-1:0]           HADDR;
    logic [1:0]                      HTRANS;
    logic [SLAVE_NUM-1:0]            HSEL_o;
    logic                            HREADY_o;
    logic [SLAVE_NUM*DATA_WIDTH-1:0] HRDATA_s;
    logic [SLAVE_NUM-1:0]            HREADYOUT_s;
    logic [SLAVE_NUM-1:0]            HRESP_s;
    logic [DATA_WIDTH-1:0]           HRDATA;
    logic                            HREADY;
    logic                            HRESP;
    logic                            TIMEOUT_o;

    modport slave (
        input  HADDR, HTRANS, HRDATA_s, HREADYOUT_s, HRESP_s,
        output HSEL_o, HREADY_o, HRDATA, HREADY, HRESP, TIMEOUT_o
    );

    modport master (
        output HADDR, HTRANS, HRDATA_s, HREADYOUT_s, HRESP_s,
        input  HSEL_o, HREADY_o, HRDATA, HREADY, HRESP, TIMEOUT_o
    );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR for NONSEQ/SEQ, zero-wait OKAY otherwise.
// Ports: HCLK, HRST (async active-low), sel (no mapped slave decoded), HTRANS, HREADY (bus ready),
//        ready/resp (registered data-phase response, valid while the default slave owns the data phase).
module ahb_default_slave
    import ahb_ic_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRST,
    input  logic       sel,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       ready,
    output logic       resp
);

    ds_state_t state;

    logic start_err_c;
    assign start_err_c = HREADY && sel && trans_active(HTRANS);

    // State and outputs move together so ready/resp are registered.
    always_ff @(posedge HCLK or negedge HRST) begin
        if (!HRST) begin
            state <= DS_IDLE;
            ready <= 1'b1;
            resp  <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE, DS_ERR2: begin
                    if (start_err_c) begin
                        state <= DS_ERR1;
                        ready <= 1'b0;
                        resp  <= HRESP_ERROR;
                    end else begin
                        state <= DS_IDLE;
                        ready <= 1'b1;
                        resp  <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state <= DS_ERR2;
                    ready <= 1'b1;
                    resp  <= HRESP_ERROR;
                end
                default: begin
                    state <= DS_IDLE;
                    ready <= 1'b1;
                    resp  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB interconnect: base/mask address decode, registered data-phase select,
// response mux and built-in default slave for unmapped transfers.
// Ports: HCLK, HRST (async active-low), bus (ahb_interconnect_if.slave):
//   HADDR/HTRANS from master, HSEL_o/HREADY_o to slaves, HRDATA_s/HREADYOUT_s/HRESP_s from slaves,
//   HRDATA/HREADY/HRESP to master, TIMEOUT_o sticky watchdog flag.
// Optional macro AHB_IC_TIMEOUT_EN: watchdog aborting data phases stalled for TIMEOUT_CYC cycles.
module ahb_interconnect
    import ahb_ic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SLAVE_NUM  = 4,
    parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLV_MASK = {4{32'hF000_0000}},
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input logic               HCLK,
    input logic               HRST,
    ahb_interconnect_if.slave bus
);

    logic [SLAVE_NUM-1:0] match_c;
    logic [SLAVE_NUM-1:0] hsel_c;
    logic                 nomatch_c;
    logic [SLAVE_NUM-1:0] dsel;       // all-zero encodes the default slave
    logic                 ds_ready;
    logic                 ds_resp;
    logic                 slv_ready_c;
    logic                 slv_resp_c;
    logic [SLAVE_NUM:0][DATA_WIDTH-1:0] rd_acc;
    logic                  hready_c;
    logic                  hresp_c;
    logic [DATA_WIDTH-1:0] hrdata_c;

    // Per-slave address compare plus read-data OR-reduction of the selected slave.
    assign rd_acc[0] = '0;
    for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_slv
        assign match_c[i] = (bus.HADDR & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                            == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_acc[i+1] = rd_acc[i]
                           | (bus.HRDATA_s[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{dsel[i]}});
    end

    // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
    assign hsel_c    = match_c & (~match_c + SLAVE_NUM'(1));
    assign nomatch_c = ~|match_c;

    assign slv_ready_c = |(dsel & bus.HREADYOUT_s);
    assign slv_resp_c  = |(dsel & bus.HRESP_s);

    // Data-phase owner advances only when the current transfer completes.
    always_ff @(posedge HCLK or negedge HRST) begin
        if (!HRST) begin
            dsel <= '0;
        end else if (hready_c) begin
            dsel <= hsel_c;
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK   (HCLK),
        .HRST   (HRST),
        .sel    (nomatch_c),
        .HTRANS (bus.HTRANS),
        .HREADY (hready_c),
        .ready  (ds_ready),
        .resp   (ds_resp)
    );

`ifdef AHB_IC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             to_second_q;
    logic             timeout_q;
    logic             to_first_c;

    // Counter saturates at the limit; a slave still low there is overridden.
    assign to_first_c = (dsel != '0) && !slv_ready_c && !to_second_q
                        && (to_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge HCLK or negedge HRST) begin
        if (!HRST) begin
            to_cnt      <= '0;
            to_second_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (hready_c) begin
                to_cnt <= '0;
            end else if ((dsel != '0) && !slv_ready_c && (to_cnt != CNT_W'(TIMEOUT_CYC))) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            to_second_q <= to_first_c;
            if (to_first_c) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.TIMEOUT_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = &{1'b0, 32'(TIMEOUT_CYC)};
    assign bus.TIMEOUT_o = 1'b0;
`endif

    // Response mux; the watchdog override has priority over the stalled slave.
    always_comb begin
        if (dsel == '0) begin
            hready_c = ds_ready;
            hresp_c  = ds_resp;
            hrdata_c = '0;
        end else begin
            hready_c = slv_ready_c;
            hresp_c  = slv_resp_c;
            hrdata_c = rd_acc[SLAVE_NUM];
        end
`ifdef AHB_IC_TIMEOUT_EN
        if (to_first_c) begin
            hready_c = 1'b0;
            hresp_c  = HRESP_ERROR;
        end else if (to_second_q) begin
            hready_c = 1'b1;
            hresp_c  = HRESP_ERROR;
            hrdata_c = '0;
        end
`endif
    end

    assign bus.HSEL_o   = hsel_c;
    assign bus.HREADY_o = hready_c;
    assign bus.HREADY   = hready_c;
    assign bus.HRESP    = hresp_c;
    assign bus.HRDATA   = hrdata_c;

endmodule
